// File: rtl/stepper_move_sequencer_pkg.sv
// Shared types and phase tables for the stepper move sequencer.
// Tables are packed so that entry i occupies bits [4*i+3:4*i].
package stepper_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int FULL_PHASES = 4;
    localparam int HALF_PHASES = 8;
    localparam int MIN_PERIOD  = 2;

    // Entry 0 sits in the LSBs: full 1100,0110,0011,1001.
    localparam logic [4*FULL_PHASES-1:0] FULL_TABLE = {
        4'b1001, 4'b0011, 4'b0110, 4'b1100
    };

    // Half: 1000,1100,0100,0110,0010,0011,0001,1001.
    localparam logic [4*HALF_PHASES-1:0] HALF_TABLE = {
        4'b1001, 4'b0001, 4'b0011, 4'b0010,
        4'b0110, 4'b0100, 4'b1100, 4'b1000
    };

    function automatic logic [3:0] phase_pattern(input logic half, input logic [2:0] idx);
        logic [3:0] pat;
        if (half) begin
            pat = HALF_TABLE[{idx, 2'b00} +: 4];
        end else begin
            pat = FULL_TABLE[{idx[1:0], 2'b00} +: 4];
        end
        return pat;
    endfunction

endpackage

// File: rtl/stepper_move_sequencer_if.sv
// Command handshake plus coil/status bundle between host logic and the sequencer.
// Master is the host side; slave is the sequencer.
interface stepper_move_sequencer_if #(
    parameter int CNT_W = 16,
    parameter int PER_W = 16,
    parameter int POS_W = 32
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_steps;
    logic [PER_W-1:0] cmd_period;
    logic             abort;
    logic [3:0]       coils;
    logic             busy;
    logic             done;
    logic [POS_W-1:0] pos;

    modport master (
        output cmd_valid, cmd_dir, cmd_steps, cmd_period, abort,
        input  cmd_ready, coils, busy, done, pos
    );

    modport slave (
        input  cmd_valid, cmd_dir, cmd_steps, cmd_period, abort,
        output cmd_ready, coils, busy, done, pos
    );
endinterface

// File: rtl/stepper_move_sequencer_phase_gen.sv
// Phase index register and coil table lookup; coils follow the index registered on a step.
// Latency: coils change on the edge where step_en is sampled; no backpressure.
module stepper_phase_gen
    import stepper_pkg::*;
#(
    parameter bit HALF_STEP = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step_en,
    input  logic       dir,
    output logic [3:0] coils
);
    localparam logic [2:0] IDX_MASK = HALF_STEP ? 3'd7 : 3'd3;

    logic [2:0] idx_q;
    logic [2:0] idx_next;

    // Masking keeps the full-step index wrapping modulo 4 in a 3-bit register.
    always_comb begin
        idx_next = (dir ? (idx_q + 3'd1) : (idx_q - 3'd1)) & IDX_MASK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= 3'd0;
        end else if (step_en) begin
            idx_q <= idx_next;
        end
    end

    assign coils = phase_pattern(HALF_STEP, idx_q);

endmodule

// File: rtl/stepper_move_sequencer.sv
// Single-axis move scheduler: accepts one move, steps every P cycles, tracks position.
// Latency: first step P edges after accept, done one cycle after last step; cmd_ready only in IDLE.
module stepper_move_sequencer
    import stepper_pkg::*;
#(
    parameter bit HALF_STEP = 1'b0,
    parameter int CNT_W     = 16,
    parameter int PER_W     = 16,
    parameter int POS_W     = 32
) (
    input  logic system1000,
    input  logic system1000_rstn,
    stepper_move_sequencer_if.slave bus
);
    localparam logic [PER_W-1:0] MIN_P = PER_W'(MIN_PERIOD);

    state_t           state_q, state_d;
    logic             dir_q, dir_d;
    logic [PER_W-1:0] reload_q, reload_d;
    logic [PER_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [POS_W-1:0] pos_q;
    logic [PER_W-1:0] period_clamped;
    logic             step_en;

    assign period_clamped = (bus.cmd_period < MIN_P) ? MIN_P : bus.cmd_period;

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state_q     <= IDLE;
            dir_q       <= 1'b0;
            reload_q    <= '0;
            timer_q     <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            reload_q    <= reload_d;
            timer_q     <= timer_d;
            remaining_q <= remaining_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        reload_d    = reload_q;
        timer_d     = timer_q;
        remaining_d = remaining_q;
        step_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    dir_d       = bus.cmd_dir;
                    reload_d    = period_clamped - PER_W'(1);
                    timer_d     = period_clamped - PER_W'(1);
                    remaining_d = bus.cmd_steps;
                    state_d     = (bus.cmd_steps == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // Abort takes priority over a step due on the same edge.
                if (bus.abort) begin
                    state_d = DONE;
                end else if (timer_q == '0) begin
                    step_en     = 1'b1;
                    timer_d     = reload_q;
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end else begin
                    timer_d = timer_q - PER_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Position wraps naturally in two's complement.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            pos_q <= '0;
        end else if (step_en) begin
            pos_q <= dir_q ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));
        end
    end

    stepper_phase_gen #(
        .HALF_STEP (HALF_STEP)
    ) u_phase_gen (
        .clk     (system1000),
        .rst_n   (system1000_rstn),
        .step_en (step_en),
        .dir     (dir_q),
        .coils   (bus.coils)
    );

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.pos       = pos_q;

endmodule

// File: tb/tb_stepper_move_sequencer.sv
// Scoreboarded bench for full-step and half-step sequencer instances sharing one clock/reset.
module tb_stepper_move_sequencer;

    typedef struct {
        int          cyc;
        logic [3:0]  coils;
        logic        done;
        logic [31:0] pos;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t qf[$];
    exp_t qh[$];
    logic [3:0] pf;
    logic [3:0] ph;

    stepper_move_sequencer_if #(.CNT_W(16), .PER_W(16), .POS_W(32)) bf ();
    stepper_move_sequencer_if #(.CNT_W(16), .PER_W(16), .POS_W(32)) bh ();

    stepper_move_sequencer #(.HALF_STEP(1'b0), .CNT_W(16), .PER_W(16), .POS_W(32)) dut_f (
        .system1000      (clk),
        .system1000_rstn (rst_n),
        .bus             (bf.slave)
    );

    stepper_move_sequencer #(.HALF_STEP(1'b1), .CNT_W(16), .PER_W(16), .POS_W(32)) dut_h (
        .system1000      (clk),
        .system1000_rstn (rst_n),
        .bus             (bh.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input bit half, input int c, input logic [3:0] co, input logic d, input int p);
        exp_t e;
        e.cyc = c; e.coils = co; e.done = d; e.pos = p;
        if (half) qh.push_back(e); else qf.push_back(e);
    endtask

    task automatic score(input bit half, input logic [3:0] co, input logic d, input logic [31:0] p);
        exp_t e;
        string tag;
        tag = half ? "half" : "full";
        total++;
        if ((half && qh.size() == 0) || (!half && qf.size() == 0)) begin
            bad++;
            $display("FAIL %s_unexpected_event: cyc=%0d coils=%b done=%b pos=%0d, none expected",
                     tag, cyc, co, d, $signed(p));
        end else begin
            if (half) e = qh.pop_front(); else e = qf.pop_front();
            if (cyc != e.cyc || co !== e.coils || d !== e.done || p !== e.pos) begin
                bad++;
                $display("FAIL %s_event: got cyc=%0d coils=%b done=%b pos=%0d expected cyc=%0d coils=%b done=%b pos=%0d",
                         tag, cyc, co, d, $signed(p), e.cyc, e.coils, e.done, $signed(e.pos));
            end
        end
    endtask

    // Monitors: an output event is any coil change or a done pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            pf = bf.coils;
        end else begin
            if (bf.coils !== pf || bf.done === 1'b1) score(1'b0, bf.coils, bf.done, bf.pos);
            pf = bf.coils;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            ph = bh.coils;
        end else begin
            if (bh.coils !== ph || bh.done === 1'b1) score(1'b1, bh.coils, bh.done, bh.pos);
            ph = bh.coils;
        end
    end

    task automatic send(input bit half, input bit dir, input int steps, input int period,
                        input bit hold, output int k);
        if (half) begin
            bh.cmd_valid = 1'b1; bh.cmd_dir = dir;
            bh.cmd_steps = 16'(steps); bh.cmd_period = 16'(period);
        end else begin
            bf.cmd_valid = 1'b1; bf.cmd_dir = dir;
            bf.cmd_steps = 16'(steps); bf.cmd_period = 16'(period);
        end
        @(posedge clk);
        #1;
        k = cyc;
        if (!hold) begin
            if (half) bh.cmd_valid = 1'b0; else bf.cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(input bit half, input string name);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(posedge clk);
            #1;
            if ((half ? bh.busy : bf.busy) === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: busy still high, required low within 400 cycles", name);
        end
    endtask

    initial begin
        int k;
        bf.cmd_valid = 1'b0; bf.cmd_dir = 1'b0; bf.cmd_steps = '0; bf.cmd_period = '0; bf.abort = 1'b0;
        bh.cmd_valid = 1'b0; bh.cmd_dir = 1'b0; bh.cmd_steps = '0; bh.cmd_period = '0; bh.abort = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("rst_coils_full", 32'(bf.coils), 32'b1100);
        chk("rst_ready_full", 32'(bf.cmd_ready), 1);
        chk("rst_busy_full", 32'(bf.busy), 0);
        chk("rst_done_full", 32'(bf.done), 0);
        chk("rst_pos_full", bf.pos, 0);
        chk("rst_coils_half", 32'(bh.coils), 32'b1000);
        chk("rst_pos_half", bh.pos, 0);

        // Forward 3 steps, period 5.
        send(1'b0, 1'b1, 3, 5, 1'b0, k);
        push(1'b0, k + 5, 4'b0110, 1'b0, 1);
        push(1'b0, k + 10, 4'b0011, 1'b0, 2);
        push(1'b0, k + 15, 4'b1001, 1'b1, 3);
        wait_idle(1'b0, "fwd3");
        chk("fwd3_pos", bf.pos, 3);

        // Zero-step move: done only.
        send(1'b0, 1'b1, 0, 7, 1'b0, k);
        push(1'b0, k, 4'b1001, 1'b1, 3);
        wait_idle(1'b0, "zero");

        // Abort on the edge where step 3 would land.
        send(1'b0, 1'b1, 10, 4, 1'b0, k);
        push(1'b0, k + 4, 4'b1100, 1'b0, 4);
        push(1'b0, k + 8, 4'b0110, 1'b0, 5);
        push(1'b0, k + 12, 4'b0110, 1'b1, 5);
        repeat (11) @(posedge clk);
        #1 bf.abort = 1'b1;
        @(posedge clk);
        #1 bf.abort = 1'b0;
        wait_idle(1'b0, "abort");
        chk("abort_pos", bf.pos, 5);

        // Held valid: second accept only after DONE returns to IDLE.
        send(1'b0, 1'b0, 1, 2, 1'b1, k);
        push(1'b0, k + 2, 4'b1100, 1'b1, 4);
        push(1'b0, k + 6, 4'b1001, 1'b1, 3);
        repeat (3) @(posedge clk);
        #1 chk("b2b_idle_gap_busy", 32'(bf.busy), 0);
        @(posedge clk);
        #1 bf.cmd_valid = 1'b0;
        chk("b2b_second_accept_busy", 32'(bf.busy), 1);
        wait_idle(1'b0, "b2b");
        chk("b2b_pos", bf.pos, 3);

        // Abort while idle is ignored.
        bf.abort = 1'b1;
        repeat (3) @(posedge clk);
        #1 bf.abort = 1'b0;
        chk("idle_abort_busy", 32'(bf.busy), 0);
        chk("idle_abort_pos", bf.pos, 3);

        // Half-step reverse, period clamped to 2.
        send(1'b1, 1'b0, 2, 1, 1'b0, k);
        push(1'b1, k + 2, 4'b1001, 1'b0, -1);
        push(1'b1, k + 4, 4'b0001, 1'b1, -2);
        wait_idle(1'b1, "rev_half");
        chk("rev_half_pos", bh.pos, 32'hFFFF_FFFE);

        // Reset mid-run after one step, with a command held through reset.
        send(1'b1, 1'b1, 10, 3, 1'b0, k);
        push(1'b1, k + 3, 4'b1001, 1'b0, -1);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        bh.cmd_valid = 1'b1; bh.cmd_dir = 1'b1; bh.cmd_steps = 16'd1; bh.cmd_period = 16'd2;
        #1;
        chk("mid_rst_coils_half", 32'(bh.coils), 32'b1000);
        chk("mid_rst_pos_half", bh.pos, 0);
        chk("mid_rst_busy_half", 32'(bh.busy), 0);
        chk("mid_rst_ready_half", 32'(bh.cmd_ready), 1);
        chk("mid_rst_coils_full", 32'(bf.coils), 32'b1100);
        chk("mid_rst_pos_full", bf.pos, 0);
        chk("mid_rst_pending", qh.size(), 0);
        qh.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send(1'b1, 1'b1, 1, 2, 1'b0, k);
        chk("post_rst_accept_busy", 32'(bh.busy), 1);
        push(1'b1, k + 2, 4'b1100, 1'b1, 1);
        wait_idle(1'b1, "post_rst");
        chk("post_rst_pos", bh.pos, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("full_queue_drained", qf.size(), 0);
        chk("half_queue_drained", qh.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stepper_move_sequencer.md
Name: stepper_move_sequencer

Overview:
- Command-driven sequencer for one stepper axis: accepts a move (direction, step count, step period) over a valid/ready handshake and emits timed coil-phase patterns.
- Tracks absolute position and signals completion.
- Sits between the host/button logic and the coil drivers of the stepper top level; it is the scheduler that decides when each phase transition is applied.

Parameters:
- HALF_STEP, 0, 0 = 4-state full-step table; 1 = 8-state half-step table
- CNT_W, 16, width of step-count field
- PER_W, 16, width of step-period field (clock cycles per step)
- POS_W, 32, width of signed position counter

Ports:
- system1000  in  1  clock
- system1000_rstn  in  1  asynchronous reset, active low
- cmd_valid  in  1  move command valid
- cmd_ready  out  1  sequencer can accept command
- cmd_dir  in  1  1 = forward, 0 = reverse
- cmd_steps  in  CNT_W  number of steps to issue
- cmd_period  in  PER_W  cycles between steps
- abort  in  1  terminate current move
- coils  out  4  coil drive pattern {A,B,C,D}
- busy  out  1  move in progress
- done  out  1  one-cycle completion pulse
- pos  out  POS_W  signed absolute step position

Behaviour:
- Clock and reset: one clock, system1000. Reset system1000_rstn is asynchronous, active low.
- Reset values:
  - state IDLE, phase index 0, so coils = table[0] (full-step 4'b1100, half-step 4'b1000)
  - cmd_ready = 1, busy = 0, done = 0, pos = 0, timer = 0, remaining = 0
- Phase tables:
  - Full-step: 1100, 0110, 0011, 1001
  - Half-step: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001
- Phase index wraps modulo N (4 or 8).
- Coils always drive table[index], including in IDLE (holding torque).
- FSM states: IDLE, RUN, DONE.
  - IDLE:
    - cmd_ready = 1.
    - On cmd_valid & cmd_ready, latch dir, load remaining = cmd_steps, timer = P-1, where P = max(cmd_period, 2).
    - If cmd_steps == 0, go to DONE; otherwise go to RUN.
  - RUN, each cycle:
    - If abort = 1: go to DONE with no step this edge. Abort wins over a coincident step.
    - Else if timer == 0: take a step (below), reload timer = P-1, decrement remaining. If remaining was 1, go to DONE on this same edge.
    - Else decrement timer.
  - DONE: done = 1 for exactly one cycle, then IDLE. cmd_ready = 0 in DONE.
- Step action:
  - dir = 1: index+1, pos+1.
  - dir = 0: index-1, pos-1.
  - pos wraps modulo 2^POS_W (two's complement).
- Timing: for a command accepted at edge k, coils change at edges k+P, k+2P, ..., k+nP. done is high in the cycle after edge k+nP.
- busy = (state != IDLE). cmd_ready = (state == IDLE).
- cmd_dir, cmd_steps and cmd_period are sampled only at acceptance; changes during RUN are ignored.
- abort in IDLE or DONE is ignored.
- A new command can be accepted in the IDLE cycle immediately after done. There is no back-to-back accept in the DONE cycle.
- Async reset mid-move: all registers return to reset values immediately. Coils snap to table[0] and pos to 0.

Decomposition:
- Shared package stepper_pkg:
  - state enum (IDLE/RUN/DONE)
  - FULL_TABLE and HALF_TABLE constants
  - phase-count constants (4/8)
  - minimum-period constant MIN_PERIOD = 2
- One sub-module: stepper_phase_gen.
  - Holds the phase index register and table lookup.
  - Inputs: step enable, dir. Output: coils.
  - The top sequencer owns the FSM, timer, remaining and pos.

Test Plan:
1. Reset release, HALF_STEP=0 -> coils=1100, cmd_ready=1, busy=0, pos=0.
2. Forward move, steps=3, period=5, accept at edge k -> coils 0110@k+5, 0011@k+10, 1001@k+15; done pulse one cycle after k+15; pos=3.
3. Reverse move, steps=2, period=1 (clamped to 2), HALF_STEP=1 from index 0 -> coils 1001 then 0001 at +2/+4; pos=-2 (all ones).
4. steps=0 -> no coil change; done asserted one cycle after accept; pos unchanged.
5. Forward steps=10, period=4; abort asserted on the same cycle timer==0 before step 3 -> only 2 steps taken; pos=2; done pulses next cycle.
6. Reset asserted mid-RUN after 1 step -> coils immediately 1100, pos=0, busy=0. A cmd_valid held through reset is accepted on the first clock after release.
